// File: rtl/store_trace_buffer.sv
// store_trace_buffer: captures CPU data-memory stores into a circular trace
// buffer and lets the user browse recent stores on a four-digit display.
module store_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_pulse,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          btn_prev,
  input  logic          btn_next,
  input  logic          btn_clear,
  output logic [31:0]   ent_addr,
  output logic [31:0]   ent_data,
  output logic [3:0]    dig3,
  output logic [3:0]    dig2,
  output logic [3:0]    dig1,
  output logic [3:0]    dig0,
  output logic [CW:0]   count,
  output logic [CW-1:0] cursor_age,
  output logic          browse,
  output logic          empty,
  output logic          overflow
);

  localparam logic [CW:0]   FULL_C    = (CW+1)'(DEPTH);
  localparam logic [CW:0]   CNT_ONE_C = (CW+1)'(1);
  localparam logic [CW-1:0] CUR_ONE_C = CW'(1);
  localparam logic [CW-1:0] CUR_MAX_C = CW'(DEPTH - 1);

  // Trace storage: {address, data} per entry.
  logic [63:0] mem_q [DEPTH];

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW:0]   count_q, count_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic          browse_q, browse_d;
  logic          overflow_q, overflow_d;
  logic [63:0]   ent_q;

  logic          capture;
  logic          cap_we;
  logic          full;
  logic [CW:0]   count_m1;
  logic [CW-1:0] rd_addr;

  assign capture  = step_pulse & memwrite;
  assign cap_we   = capture & ~btn_clear;
  assign full     = (count_q == FULL_C);
  assign count_m1 = count_q - CNT_ONE_C;
  // Entry of age k lives at slot (wr_ptr - 1 - k); read from next-state so the
  // registered output follows state changes without an extra pipeline stage.
  assign rd_addr  = wr_ptr_d - CUR_ONE_C - cursor_d;

  // Next-state logic: clear beats capture, capture beats navigation.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    cursor_d   = cursor_q;
    browse_d   = browse_q;
    overflow_d = overflow_q;
    if (btn_clear) begin
      count_d    = '0;
      cursor_d   = '0;
      browse_d   = 1'b0;
      overflow_d = 1'b0;
    end else if (capture) begin
      wr_ptr_d = wr_ptr_q + CUR_ONE_C;
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE_C;
      end
      // Keep pointing at the same store unless it was the one overwritten.
      if (browse_q && !(full && cursor_q == CUR_MAX_C)) begin
        cursor_d = cursor_q + CUR_ONE_C;
      end
    end else if (btn_prev && !btn_next) begin
      if (count_q >= (CW+1)'(2)) begin
        if (!browse_q) begin
          browse_d = 1'b1;
          cursor_d = CUR_ONE_C;
        end else if ({1'b0, cursor_q} < count_m1) begin
          cursor_d = cursor_q + CUR_ONE_C;
        end
      end
    end else if (btn_next && !btn_prev && browse_q) begin
      if (cursor_q > CUR_ONE_C) begin
        cursor_d = cursor_q - CUR_ONE_C;
      end else begin
        cursor_d = '0;
        browse_d = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cursor_q   <= '0;
      browse_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cursor_q   <= cursor_d;
      browse_q   <= browse_d;
      overflow_q <= overflow_d;
    end
  end

  // Trace storage write port; contents are not cleared on reset.
  always_ff @(posedge clk) begin
    if (cap_we && !reset) begin
      mem_q[wr_ptr_q] <= {dataadr, writedata};
    end
  end

  // Registered read of the selected entry; an empty buffer shows zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
    end else if (count_d == '0) begin
      ent_q <= '0;
    end else begin
      ent_q <= mem_q[rd_addr];
    end
  end

  assign ent_addr   = ent_q[63:32];
  assign ent_data   = ent_q[31:0];
  assign dig3       = ent_q[39:36];
  assign dig2       = ent_q[35:32];
  assign dig1       = ent_q[7:4];
  assign dig0       = ent_q[3:0];
  assign count      = count_q;
  assign cursor_age = cursor_q;
  assign browse     = browse_q;
  assign empty      = (count_q == '0);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_store_trace_buffer.sv
// tb_store_trace_buffer: directed bench with a trace model and a scoreboard of
// expected selected entries for store_trace_buffer.
module tb_store_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          step_pulse = 1'b0;
  logic          memwrite = 1'b0;
  logic [31:0]   dataadr = '0;
  logic [31:0]   writedata = '0;
  logic          btn_prev = 1'b0;
  logic          btn_next = 1'b0;
  logic          btn_clear = 1'b0;
  logic [31:0]   ent_addr, ent_data;
  logic [3:0]    dig3, dig2, dig1, dig0;
  logic [CW:0]   count;
  logic [CW-1:0] cursor_age;
  logic          browse, empty, overflow;

  int checks = 0;
  int errors = 0;

  logic [63:0] trace_q[$];   // model: oldest at front, newest at back
  logic [63:0] exp_q[$];     // scoreboard of expected {addr,data}
  logic [63:0] saved;

  store_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .step_pulse(step_pulse), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .btn_prev(btn_prev),
    .btn_next(btn_next), .btn_clear(btn_clear), .ent_addr(ent_addr),
    .ent_data(ent_data), .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
    .count(count), .cursor_age(cursor_age), .browse(browse), .empty(empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Push the model's entry of the given age onto the scoreboard.
  task automatic expect_age(input int age);
    if (age < trace_q.size()) exp_q.push_back(trace_q[trace_q.size() - 1 - age]);
    else exp_q.push_back(64'h0);
  endtask

  // Pop the scoreboard and compare against the displayed entry and digits.
  task automatic check_ent(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sbempty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_ent"}, {ent_addr, ent_data}, e);
      chk({tag, "_dig"}, {48'h0, dig3, dig2, dig1, dig0}, {48'h0, e[39:32], e[7:0]});
    end
  endtask

  task automatic capture(input logic [31:0] a, input logic [31:0] d);
    step_pulse = 1'b1; memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    step_pulse = 1'b0; memwrite = 1'b0;
    trace_q.push_back({a, d});
    if (trace_q.size() > DEPTH) void'(trace_q.pop_front());
  endtask

  task automatic prev(input int n);
    for (int i = 0; i < n; i++) begin
      btn_prev = 1'b1; tick(); btn_prev = 1'b0;
    end
  endtask

  task automatic next(input int n);
    for (int i = 0; i < n; i++) begin
      btn_next = 1'b1; tick(); btn_next = 1'b0;
    end
  endtask

  task automatic clear_model();
    trace_q.delete();
  endtask

  initial begin
    // Reset
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ctrl", {61'h0, browse, overflow, |cursor_age}, 64'd0);
    exp_q.push_back(64'h0);
    check_ent("rst");

    // Three captures, LIVE display tracks newest
    capture(32'h10, 32'h5);
    capture(32'h14, 32'h7);
    capture(32'h18, 32'hC);
    tick();
    chk("cap3_count", 64'(count), 64'd3);
    chk("cap3_browse", 64'(browse), 64'd0);
    chk("cap3_ovf", 64'(overflow), 64'd0);
    expect_age(0);
    check_ent("cap3");

    // Browse older, saturate, then return to LIVE
    prev(2); tick();
    chk("prev2_browse", 64'(browse), 64'd1);
    chk("prev2_age", 64'(cursor_age), 64'd2);
    expect_age(2);
    check_ent("prev2");
    prev(1); tick();
    chk("prev3_age", 64'(cursor_age), 64'd2);
    next(2); tick();
    chk("next2_browse", 64'(browse), 64'd0);
    chk("next2_age", 64'(cursor_age), 64'd0);
    expect_age(0);
    check_ent("next2");

    // Capture and btn_prev together: capture wins
    step_pulse = 1'b1; memwrite = 1'b1; dataadr = 32'h1C; writedata = 32'h9; btn_prev = 1'b1;
    tick();
    step_pulse = 1'b0; memwrite = 1'b0; btn_prev = 1'b0;
    trace_q.push_back({32'h1C, 32'h9});
    chk("capprev_browse", 64'(browse), 64'd0);
    chk("capprev_count", 64'(count), 64'd4);
    tick();
    expect_age(0);
    check_ent("capprev");

    // memwrite held 5 cycles with a single step_pulse
    memwrite = 1'b1; dataadr = 32'h20; writedata = 32'h33;
    for (int i = 0; i < 5; i++) begin
      step_pulse = (i == 2);
      tick();
    end
    step_pulse = 1'b0; memwrite = 1'b0;
    trace_q.push_back({32'h20, 32'h33});
    chk("hold_count", 64'(count), 64'd5);
    expect_age(0);
    check_ent("hold");

    // Clear coincident with a capture drops the store
    btn_clear = 1'b1; step_pulse = 1'b1; memwrite = 1'b1; dataadr = 32'h44; writedata = 32'h44;
    tick();
    btn_clear = 1'b0; step_pulse = 1'b0; memwrite = 1'b0;
    clear_model();
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_empty", 64'(empty), 64'd1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    tick();
    exp_q.push_back(64'h0);
    check_ent("clr");
    prev(1); tick();
    chk("clr_prev_browse", 64'(browse), 64'd0);

    // Overflow: 17 captures with data 1..17
    for (int i = 1; i <= 17; i++) capture(32'h100 + 32'(4 * i), 32'(i));
    tick();
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    prev(15); tick();
    chk("ovf_age15", 64'(cursor_age), 64'd15);
    chk("ovf_data15", 64'(ent_data), 64'd2);
    expect_age(15);
    check_ent("ovf15");

    // Capture at the oldest slot while full: cursor holds, new oldest shown
    capture(32'h200, 32'd18); tick();
    chk("full_cap_age", 64'(cursor_age), 64'd15);
    chk("full_cap_data", 64'(ent_data), 64'd3);
    expect_age(15);
    check_ent("fullcap");

    // Capture while browsing mid-buffer keeps the same store selected
    next(10); tick();
    chk("mid_age", 64'(cursor_age), 64'd5);
    saved = {ent_addr, ent_data};
    expect_age(5);
    check_ent("mid_before");
    capture(32'h204, 32'd19); tick();
    chk("mid_cap_age", 64'(cursor_age), 64'd6);
    exp_q.push_back(trace_q[trace_q.size() - 1 - 6]);
    check_ent("mid_after");

    // Reset while in BROWSE with four entries
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) capture(32'h300 + 32'(i), 32'h50 + 32'(i));
    prev(1); tick();
    chk("pre_rst_browse", 64'(browse), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    clear_model();
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_ctrl", {60'h0, browse, overflow, empty, |cursor_age}, 64'h2);
    exp_q.push_back(64'h0);
    check_ent("rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
